// File: rtl/bus_uart_bridge_pkg.sv
// Shared definitions for the serial-to-bus debug bridge.
//   state_e   : frame parser / bus request FSM states
//   CMD_*     : host command bytes
//   RSP_*     : reply bytes sent back to the host
package bus_uart_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StReq,
        StWaitAck,
        StReply
    } state_e;

    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_TO  = 8'h54;  // 'T'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

endpackage

// File: rtl/bus_uart_bridge_phy.sv
// 8N1 UART serialiser/deserialiser, single clock domain.
//   clk, rst_n          : clock, async active-low reset
//   ser_rx / ser_tx     : serial lines, idle high
//   rx_data, rx_valid   : received byte, rx_valid is a 1-cycle pulse
//   tx_data, tx_start   : byte to send, accepted when tx_busy is low
//   tx_busy             : low during the final cycle of a stop bit so bytes can chain
module uart_phy #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);
    localparam int unsigned CW = $clog2(CLK_DIV);

    logic          rx_s1_q, rx_s2_q, rx_prev_q, rx_act_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;

    logic          tx_act_q, tx_last;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic [9:0]    tx_sh_q;

    // rx_bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_act_q  <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_s1_q   <= ser_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_valid  <= 1'b0;
            if (!rx_act_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_act_q <= 1'b1;
                    rx_cnt_q <= CW'(CLK_DIV / 2 - 1);
                    rx_bit_q <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= CW'(CLK_DIV - 1);
                if (rx_bit_q == 4'd0) begin
                    // Start bit high again at mid-bit: treat as a glitch.
                    if (rx_s2_q) rx_act_q <= 1'b0;
                    else         rx_bit_q <= 4'd1;
                end else if (rx_bit_q == 4'd9) begin
                    rx_act_q <= 1'b0;
                    if (rx_s2_q) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh_q;
                    end
                end else begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 4'd1;
                end
            end
        end
    end

    assign tx_last = tx_act_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd9);
    assign tx_busy = tx_act_q && !tx_last;
    assign ser_tx  = tx_act_q ? tx_sh_q[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_act_q <= 1'b0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '1;
        end else if (tx_start && !tx_busy) begin
            tx_act_q <= 1'b1;
            tx_sh_q  <= {1'b1, tx_data, 1'b0};
            tx_cnt_q <= CW'(CLK_DIV - 1);
            tx_bit_q <= '0;
        end else if (tx_act_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end else if (tx_last) begin
                tx_act_q <= 1'b0;
            end else begin
                tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
                tx_bit_q <= tx_bit_q + 4'd1;
                tx_cnt_q <= CW'(CLK_DIV - 1);
            end
        end
    end

endmodule

// File: rtl/bus_uart_bridge.sv
// Serial-to-bus debug bridge: parses 'R'/'W' frames from the host UART, issues one
// 32-bit bus access and answers with 'K' (+ read data), 'T' on timeout or '?' for junk.
//   bus_clk, bus_reset_l          : clock, async active-low reset
//   ser_rx, ser_tx                : host UART, 8N1, CLK_DIV cycles per bit
//   bus_addr/bus_wr_data/bus_be   : request fields, held from REQ through WAIT_ACK
//   bus_rd_req/bus_wr_req         : single-cycle request pulses
//   bus_rd_data/bus_rd_ack        : read return
//   bus_wr_ack                    : write completion
//   busy                          : high whenever the FSM is not idle
module bus_uart_bridge
    import bus_uart_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 868,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned RX_IDLE     = 1000000
) (
    input  logic        bus_clk,
    input  logic        bus_reset_l,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_data,
    output logic [3:0]  bus_be,
    output logic        bus_rd_req,
    output logic        bus_wr_req,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rd_ack,
    input  logic        bus_wr_ack,
    output logic        busy
);
    localparam int unsigned TO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned IDLE_W = $clog2(RX_IDLE + 1);

    state_e              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         addr_q, addr_d, data_q, data_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [39:0]         rep_q, rep_d;      // reply bytes, MSB first
    logic [2:0]          rep_left_q, rep_left_d;
    logic                err_pend_q, err_pend_d;

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_start, tx_busy;

    uart_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk      (bus_clk),
        .rst_n    (bus_reset_l),
        .ser_rx   (ser_rx),
        .ser_tx   (ser_tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state_q    <= StIdle;
            is_wr_q    <= 1'b0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            to_cnt_q   <= '0;
            idle_cnt_q <= '0;
            rep_q      <= '0;
            rep_left_q <= '0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            to_cnt_q   <= to_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rep_q      <= rep_d;
            rep_left_q <= rep_left_d;
            err_pend_q <= err_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        to_cnt_d   = to_cnt_q;
        idle_cnt_d = idle_cnt_q;
        rep_d      = rep_q;
        rep_left_d = rep_left_q;
        err_pend_d = err_pend_q;
        tx_start   = 1'b0;
        tx_data    = rep_q[39:32];

        // '?' is sent without leaving IDLE, so it owns the transmitter when pending.
        if (err_pend_q && !tx_busy) begin
            tx_start   = 1'b1;
            tx_data    = RSP_ERR;
            err_pend_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                byte_cnt_d = '0;
                idle_cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == CMD_RD || rx_data == CMD_WR) begin
                        is_wr_d = (rx_data == CMD_WR);
                        state_d = StGetAddr;
                    end else begin
                        err_pend_d = 1'b1;
                    end
                end
            end
            StGetAddr, StGetData: begin
                if (rx_valid) begin
                    idle_cnt_d = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == StGetAddr) addr_d = {addr_q[23:0], rx_data};
                    else                      data_d = {data_q[23:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (state_q == StGetAddr && is_wr_q) ? StGetData : StReq;
                    end
                end else if (idle_cnt_q == IDLE_W'(RX_IDLE - 1)) begin
                    state_d = StIdle;  // host went quiet mid-frame: resync silently
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            StReq: begin
                to_cnt_d = '0;
                state_d  = StWaitAck;
            end
            StWaitAck: begin
                if (is_wr_q ? bus_wr_ack : bus_rd_ack) begin
                    rep_d      = {RSP_OK, (is_wr_q ? 32'h0 : bus_rd_data)};
                    rep_left_d = is_wr_q ? 3'd1 : 3'd5;
                    state_d    = StReply;
                end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    rep_d      = {RSP_TO, 32'h0};
                    rep_left_d = 3'd1;
                    state_d    = StReply;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StReply: begin
                if (!err_pend_q && !tx_busy) begin
                    if (rep_left_q != '0) begin
                        tx_start   = 1'b1;
                        tx_data    = rep_q[39:32];
                        rep_d      = {rep_q[31:0], 8'h00};
                        rep_left_d = rep_left_q - 3'd1;
                    end else begin
                        state_d = StIdle;  // last stop bit has finished
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign bus_rd_req  = (state_q == StReq) && !is_wr_q;
    assign bus_wr_req  = (state_q == StReq) && is_wr_q;
    assign bus_be      = (state_q == StReq || state_q == StWaitAck) ? 4'hF : 4'h0;
    assign bus_addr    = {addr_q[31:2], 2'b00};
    assign bus_wr_data = data_q;

endmodule
